// File: rtl/nfca_rx_frame_ctrl_if.sv
// nfca_rx_frame_ctrl_if: bit-parser inputs, frame results and control between the NFC-A RX framer and its host.
interface nfca_rx_frame_ctrl_if;
    logic       start;
    logic       rx_bit_en;
    logic       rx_bit;
    logic       rx_end;
    logic       rx_end_col;
    logic       rx_end_err;
    logic       rx_gate;
    logic       busy;
    logic       out_byte_en;
    logic [7:0] out_byte;
    logic [3:0] out_nbits;
    logic       done;
    logic [2:0] status;
    logic [6:0] byte_cnt;
    modport master (
        output start, rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err,
        input  rx_gate, busy, out_byte_en, out_byte, out_nbits, done, status, byte_cnt
    );
    modport slave (
        input  start, rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err,
        output rx_gate, busy, out_byte_en, out_byte, out_nbits, done, status, byte_cnt
    );
endinterface

// File: rtl/nfca_rx_frame_ctrl.sv
// nfca_rx_frame_ctrl: groups received NFC-A bits into bytes with odd parity, frame-wait timeout and overflow handling.
module nfca_rx_frame_ctrl #(
    parameter logic [23:0] TIMEOUT   = 24'd813600,
    parameter logic [6:0]  MAX_BYTES = 7'd64
) (
    input logic clk,
    input logic rst,
    nfca_rx_frame_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT, RECV, DRAIN, DONE} state_t;
    localparam logic [23:0] TLAST = TIMEOUT - 24'd1;
    state_t      state, state_n;
    logic [23:0] timer, timer_n;
    logic [3:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic [6:0]  cnt, cnt_n;
    logic        pflag, pflag_n;
    logic        gate, gate_n, busy, busy_n, ben, ben_n, done, done_n;
    logic [7:0]  obyte, obyte_n;
    logic [3:0]  onb, onb_n;
    logic [2:0]  stat, stat_n;
    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = idx;
        shreg_n = shreg;
        cnt_n   = cnt;
        pflag_n = pflag;
        ben_n   = 1'b0;
        obyte_n = obyte;
        onb_n   = onb;
        done_n  = 1'b0;
        stat_n  = stat;
        case (state)
            IDLE: if (bus.start) begin
                state_n = WAIT;
                timer_n = '0;
                idx_n   = '0;
                cnt_n   = '0;
                pflag_n = 1'b0;
                shreg_n = '0;
            end
            WAIT, RECV: begin
                if (state == WAIT) timer_n = timer + 24'd1;
                // an end in the same cycle as a bit wins and drops the bit
                if (bus.rx_end) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    stat_n  = bus.rx_end_err ? 3'd5 : bus.rx_end_col ? 3'd2 : pflag ? 3'd3 : 3'd0;
                    if (idx != 4'd0) begin
                        ben_n   = 1'b1;
                        obyte_n = shreg;
                        onb_n   = idx;
                    end
                end else if (bus.rx_bit_en) begin
                    if (cnt == MAX_BYTES) state_n = DRAIN;
                    else begin
                        state_n = RECV;
                        if (idx == 4'd8) begin
                            ben_n   = 1'b1;
                            obyte_n = shreg;
                            onb_n   = 4'd8;
                            cnt_n   = cnt + 7'd1;
                            idx_n   = '0;
                            shreg_n = '0;
                            if (!(^shreg ^ bus.rx_bit)) pflag_n = 1'b1;
                        end else begin
                            shreg_n[idx[2:0]] = bus.rx_bit;
                            idx_n = idx + 4'd1;
                        end
                    end
                end else if (state == WAIT && timer == TLAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    stat_n  = 3'd1;
                end
            end
            DRAIN: if (bus.rx_end) begin
                state_n = DONE;
                done_n  = 1'b1;
                stat_n  = 3'd4;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        gate_n = state_n == WAIT || state_n == RECV || state_n == DRAIN;
        busy_n = state_n != IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            shreg <= '0;
            cnt   <= '0;
            pflag <= 1'b0;
            gate  <= 1'b0;
            busy  <= 1'b0;
            ben   <= 1'b0;
            obyte <= '0;
            onb   <= '0;
            done  <= 1'b0;
            stat  <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
            pflag <= pflag_n;
            gate  <= gate_n;
            busy  <= busy_n;
            ben   <= ben_n;
            obyte <= obyte_n;
            onb   <= onb_n;
            done  <= done_n;
            stat  <= stat_n;
        end
    end
    assign bus.rx_gate     = gate;
    assign bus.busy        = busy;
    assign bus.out_byte_en = ben;
    assign bus.out_byte    = obyte;
    assign bus.out_nbits   = onb;
    assign bus.done        = done;
    assign bus.status      = stat;
    assign bus.byte_cnt    = cnt;
endmodule

// File: tb/tb_nfca_rx_frame_ctrl.sv
// tb_nfca_rx_frame_ctrl: directed and random frames checked by a queue scoreboard against a list-based frame model.
module tb_nfca_rx_frame_ctrl;
    localparam int TMO  = 100;
    localparam int MAXB = 2;
    typedef struct {logic [7:0] b; logic [3:0] n;} byte_t;
    typedef struct {logic [2:0] st; logic [6:0] cnt; bit wb; int gate;} done_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, failures = 0, gate_run = 0;
    byte_t exp_b[$];
    done_t exp_d[$];
    bit fbits[$];
    byte_t eb;
    done_t ed;
    nfca_rx_frame_ctrl_if bus();
    nfca_rx_frame_ctrl #(.TIMEOUT(24'(TMO)), .MAX_BYTES(7'(MAXB))) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst) gate_run = 0;
        else begin
            if (bus.out_byte_en) begin
                if (exp_b.size() == 0) chk("unexpected_byte", 32'({bus.out_nbits, bus.out_byte}), 32'hFFFF);
                else begin
                    eb = exp_b.pop_front();
                    chk("byte", 32'({bus.out_nbits, bus.out_byte}), 32'({eb.n, eb.b}));
                end
            end
            if (bus.done) begin
                if (exp_d.size() == 0) chk("unexpected_done", 32'(bus.status), 32'hFFFF);
                else begin
                    ed = exp_d.pop_front();
                    chk("status", 32'(bus.status), 32'(ed.st));
                    chk("byte_cnt", 32'(bus.byte_cnt), 32'(ed.cnt));
                    chk("byte_with_done", 32'(bus.out_byte_en), 32'(ed.wb));
                    chk("gate_low_at_done", 32'(bus.rx_gate), 32'd0);
                    if (ed.gate >= 0) chk("wait_cycles", 32'(gate_run), 32'(ed.gate));
                end
            end
            gate_run = bus.rx_gate ? gate_run + 1 : 0;
        end
    end
    task automatic push_byte(input logic [7:0] d, input bit p);
        for (int i = 0; i < 8; i++) fbits.push_back(d[i]);
        fbits.push_back(p);
    endtask
    // frame-level model: the bit list is cut into 9-bit groups
    task automatic model(input bit col, input bit err);
        int n = fbits.size();
        int full = n / 9;
        int rem = n % 9;
        bit pf = 0;
        logic [7:0] v;
        if (n > 9 * MAXB) begin
            for (int g = 0; g < MAXB; g++) begin
                for (int j = 0; j < 8; j++) v[j] = fbits[g*9+j];
                exp_b.push_back('{b: v, n: 4'd8});
            end
            exp_d.push_back('{st: 3'd4, cnt: 7'(MAXB), wb: 1'b0, gate: -1});
        end else begin
            for (int g = 0; g < full; g++) begin
                for (int j = 0; j < 8; j++) v[j] = fbits[g*9+j];
                if (($countones(v) + int'(fbits[g*9+8])) % 2 == 0) pf = 1;
                exp_b.push_back('{b: v, n: 4'd8});
            end
            if (rem > 0) begin
                v = '0;
                for (int j = 0; j < rem; j++) v[j] = fbits[full*9+j];
                exp_b.push_back('{b: v, n: 4'(rem)});
            end
            exp_d.push_back('{st: err ? 3'd5 : col ? 3'd2 : pf ? 3'd3 : 3'd0, cnt: 7'(full), wb: rem > 0, gate: -1});
        end
    endtask
    task automatic send_bits();
        foreach (fbits[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.rx_bit_en = 1'b1;
            bus.rx_bit = fbits[i];
            @(negedge clk) bus.rx_bit_en = 1'b0;
        end
    endtask
    task automatic send_frame(input bit col, input bit err, input bit drop);
        model(col, err);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        send_bits();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.rx_end = 1'b1;
        bus.rx_end_col = col;
        bus.rx_end_err = err;
        bus.rx_bit_en = drop;
        bus.rx_bit = 1'($urandom);
        @(negedge clk) {bus.rx_end, bus.rx_end_col, bus.rx_end_err, bus.rx_bit_en} = 4'd0;
        repeat (4) @(negedge clk);
        fbits.delete();
    endtask
    task automatic chk_reset_outs(input string name);
        chk(name, 32'({bus.rx_gate, bus.busy, bus.out_byte_en, bus.out_byte, bus.out_nbits,
                       bus.done, bus.status, bus.byte_cnt}), 32'd0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        {bus.start, bus.rx_bit_en, bus.rx_bit, bus.rx_end, bus.rx_end_col, bus.rx_end_err} = 6'd0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset_outputs");
        rst = 1'b0;
        // timeout, with a second start inside WAIT that must be ignored
        exp_d.push_back('{st: 3'd1, cnt: 7'd0, wb: 1'b0, gate: TMO});
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (40) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (TMO + 4) @(negedge clk);
        push_byte(8'hA5, 1'b1);
        push_byte(8'h3C, 1'b1);
        send_frame(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) fbits.push_back(i == 1 || i == 2 || i == 5);
        send_frame(1'b0, 1'b0, 1'b0);
        push_byte(8'h01, 1'b1);
        send_frame(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) fbits.push_back(1'($urandom));
        send_frame(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) fbits.push_back(1'($urandom));
        send_frame(1'b1, 1'b1, 1'b0);
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        send_frame(1'b0, 1'b0, 1'b1);
        push_byte(8'h5A, 1'b1);
        send_frame(1'b0, 1'b0, 1'b1);
        // reset mid-frame aborts it silently
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        push_byte(8'hC3, 1'b1);
        fbits = fbits[0:4];
        send_bits();
        fbits.delete();
        #2 rst = 1'b1;
        #1 chk_reset_outs("reset_mid_frame");
        @(negedge clk) rst = 1'b0;
        push_byte(8'h96, 1'b0);
        send_frame(1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 40; f++) begin
            for (int g = 0; g < 4; g++) begin
                logic [7:0] d = 8'($urandom);
                push_byte(d, ($urandom_range(0, 3) == 0) ? ^d : ~^d);
            end
            while (fbits.size() > $urandom_range(0, 30)) void'(fbits.pop_back());
            send_frame(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 1'($urandom));
            repeat (3) @(negedge clk) {bus.rx_bit_en, bus.rx_end, bus.rx_bit} = 3'($urandom);
            @(negedge clk) {bus.rx_bit_en, bus.rx_end, bus.rx_bit} = 3'd0;
        end
        repeat (5) @(negedge clk);
        chk("bytes_left", 32'(exp_b.size()), 32'd0);
        chk("dones_left", 32'(exp_d.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nfca_rx_frame_ctrl.md
NFCA_RX_FRAME_CTRL -- requirements
Module: nfca_rx_frame_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 24'd813600, meaning the frame-wait limit in clk cycles (10 ms at 81.36 MHz).
REQ-002 SHALL provide parameter MAX_BYTES, default 7'd64, meaning the maximum number of bytes accepted per frame.
REQ-003 clk  in  1  system clock, 81.36 MHz.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse that arms reception after a TX frame ends.
REQ-006 rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err  in  1 each  bit-parser outputs.
REQ-007 rx_gate  out  1  enables the upstream bit parser while armed.
REQ-008 busy  out  1  high in any state except IDLE.
REQ-009 out_byte_en  out  1  one-cycle strobe; out_byte and out_nbits are valid when it is high.
REQ-010 out_byte  out  8  received data byte, LSB = first bit received.
REQ-011 out_nbits  out  4  number of valid bits in out_byte, 1..8.
REQ-012 done  out  1  one-cycle end-of-frame pulse.
REQ-013 status  out  3  result, valid when done is high: 0 OK, 1 TIMEOUT, 2 COLLISION, 3 PARITY, 4 OVERFLOW, 5 RXERR.
REQ-014 byte_cnt  out  7  number of complete 8-bit bytes emitted; valid when done is high.

Function
REQ-015 States SHALL be IDLE, WAIT, RECV, DRAIN and DONE; rx_gate=1 only in WAIT, RECV and DRAIN.
REQ-016 In IDLE, start=1 SHALL go to WAIT and clear the timer, bit index, byte_cnt and parity flag; start SHALL be ignored in every other state.
REQ-017 In WAIT, the timer SHALL increment each cycle; if no rx_bit_en or rx_end has arrived, done SHALL pulse with status=1 exactly TIMEOUT cycles after the cycle in which start was sampled.
REQ-018 In WAIT, the first rx_bit_en SHALL be processed as data bit 0 and the state SHALL move to RECV; rx_end in WAIT SHALL be handled as in RECV.
REQ-019 In RECV, bits SHALL be grouped 9 per byte: indices 0..7 are data, shifted in LSB first; index 8 is odd parity.
REQ-020 On the parity bit, out_byte_en SHALL pulse the next cycle with out_nbits=8; byte_cnt SHALL increment and the bit index SHALL wrap to 0.
REQ-021 A parity bit that makes the 9-bit group have even weight SHALL set a sticky parity flag; the byte SHALL still be emitted.
REQ-022 An rx_bit_en while byte_cnt==MAX_BYTES SHALL go to DRAIN; DRAIN SHALL discard all bits until rx_end, then pulse done with status=4.
REQ-023 rx_end in RECV SHALL cause done to pulse the next cycle.
REQ-024 If that end arrives with 1..7 pending data bits, out_byte_en SHALL pulse in the same cycle as done, with out_nbits=the pending count and unused upper bits=0; this covers a 7-bit short frame.
REQ-025 If that end arrives with 8 data bits pending and no parity bit, the byte SHALL be emitted with out_nbits=8, but byte_cnt SHALL NOT increment.
REQ-026 Status priority at rx_end SHALL be: rx_end_err gives 5, else rx_end_col gives 2, else the parity flag gives 3, else 0.
REQ-027 rx_bit_en and rx_end in the same cycle: rx_end SHALL win and the bit SHALL be dropped.
REQ-028 DONE SHALL last 1 cycle and then return to IDLE; rx_* inputs SHALL be ignored in IDLE and DONE.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE and clear timer, bit index, byte_cnt, parity flag and shift register.
REQ-031 While rst=1, outputs SHALL be 0: rx_gate, busy, out_byte_en, out_byte, out_nbits, done, status and byte_cnt.
REQ-032 rst asserted mid-frame SHALL abort the frame with no done pulse; the first start after release SHALL be accepted normally.

Verification
REQ-033 Bench: TIMEOUT=100, start, no input -> done=1, status=1 exactly 100 cycles after start; rx_gate drops with done.
REQ-034 Bench: 18 bits forming 0xA5 (p=1) and 0x3C (p=1), then rx_end -> two out_byte_en with nbits=8 and bytes A5, 3C; then done, status=0, byte_cnt=2.
REQ-035 Bench: 7 bits 0x26, then rx_end -> out_byte_en with byte=0x26, nbits=7, in the same cycle as done; status=0, byte_cnt=0.
REQ-036 Bench: byte 0x01 with parity=1, then rx_end -> byte 0x01 emitted; status=3.
REQ-037 Bench: 4 bits, then rx_end with rx_end_col=1 -> out_nbits=4, status=2; a separate frame ending with both rx_end_err=1 and rx_end_col=1 -> status=5.
REQ-038 Bench: MAX_BYTES=2, 3 full bytes, then rx_end -> 2 bytes emitted, then done with status=4; rst pulse mid-RECV -> no done pulse, and the next start is accepted.
